// File: rtl/demux32_deser_pkg.sv
// Shared CPU package: word width and bit-index type used by the serial
// debug/load path.
package demux32_deser_pkg;

    localparam int WORD_W = 32;
    localparam int IDX_W  = $clog2(WORD_W);

    typedef logic [IDX_W-1:0] bit_idx_t;

endpackage : demux32_deser_pkg

// File: rtl/demux32_deser_decoder5_32.sv
// Combinational one-hot decoder with enable: structural inverse of the
// 32:1 bit mux used by the serializer. Drives the shadow write enables.
import demux32_deser_pkg::*;

module decoder5_32 #(
    parameter int WIDTH = WORD_W,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] sel,
    input  logic             en,
    output logic [WIDTH-1:0] onehot
);

    // Assert exactly one enable line when en is high, none otherwise.
    always_comb begin
        onehot = {WIDTH{1'b0}};
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = {WIDTH{1'b0}};
        end
    end

endmodule : decoder5_32

// File: rtl/demux32_deser.sv
// Serial-to-parallel receiver. Each valid beat steers bit_in into the
// shadow word position given by the running index; the 32nd beat hands the
// completed word to a valid/ready output register.
import demux32_deser_pkg::*;

module demux32_deser #(
    parameter int WIDTH = WORD_W,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [IDX_W-1:0] sel_out,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [IDX_W-1:0] sel_r;
    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] word_r;
    logic             valid_r;
    logic             overrun_r;
    logic             busy_r;

    logic [IDX_W-1:0] idx_s;
    logic [WIDTH-1:0] base_s;
    logic [WIDTH-1:0] we_s;
    logic [WIDTH-1:0] shadow_next_s;
    logic [IDX_W-1:0] sel_next_s;
    logic             complete_s;
    logic             consume_s;
    logic             load_s;
    logic             drop_s;
    logic             valid_next_s;

    // One write-enable line per shadow bit, gated by bit_valid.
    decoder5_32 #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_dec (
        .sel    (idx_s),
        .en     (bit_valid),
        .onehot (we_s)
    );

    // start restarts the frame before this beat's bit is placed, so a bit
    // arriving with start always lands in position 0.
    always_comb begin
        idx_s  = sel_r;
        base_s = shadow_r;
        if (start) begin
            idx_s  = {IDX_W{1'b0}};
            base_s = {WIDTH{1'b0}};
        end else begin
            idx_s  = sel_r;
            base_s = shadow_r;
        end
    end

    // Next shadow, next index, completion and output handshake decisions.
    always_comb begin
        shadow_next_s = (base_s & ~we_s) | (we_s & {WIDTH{bit_in}});
        sel_next_s    = idx_s;
        if (bit_valid) begin
            sel_next_s = idx_s + IDX_ONE;
        end else begin
            sel_next_s = idx_s;
        end
        complete_s   = bit_valid && (idx_s == LAST_IDX);
        consume_s    = valid_r && word_ready;
        // A completed word is accepted only if the output slot is free or is
        // being emptied on this same edge; otherwise it is dropped.
        load_s       = complete_s && (!valid_r || word_ready);
        drop_s       = complete_s && valid_r && !word_ready;
        valid_next_s = valid_r;
        if (load_s) begin
            valid_next_s = 1'b1;
        end else if (consume_s) begin
            valid_next_s = 1'b0;
        end else begin
            valid_next_s = valid_r;
        end
    end

    // Fill path: index counter, shadow word and the derived busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r    <= {IDX_W{1'b0}};
            shadow_r <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            sel_r    <= sel_next_s;
            shadow_r <= shadow_next_s;
            busy_r   <= (sel_next_s != {IDX_W{1'b0}});
        end
    end

    // Output path: held word, valid flag and sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (load_s) begin
                word_r <= shadow_next_s;
            end else begin
                word_r <= word_r;
            end
            valid_r <= valid_next_s;
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign sel_out    = sel_r;
    assign word_out   = word_r;
    assign word_valid = valid_r;
    assign busy       = busy_r;
    assign overrun    = overrun_r;

endmodule : demux32_deser

// File: tb/tb_demux32_deser.sv
// Self-checking bench for demux32_deser: directed frames with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based model of the receiver.
module tb_demux32_deser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        word_ready = 1'b0;
    logic [4:0]  sel_out;
    logic [31:0] word_out;
    logic        word_valid;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    demux32_deser dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .sel_out    (sel_out),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Model: bits of the frame in progress, plus the output slot.
    bit          q[$];
    logic [31:0] m_word = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_over = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_word  = 32'h0;
            m_valid = 1'b0;
            m_over  = 1'b0;
        end else begin
            bit          loaded;
            bit          consume;
            logic [31:0] w;
            loaded  = 1'b0;
            consume = m_valid && word_ready;
            if (start) q.delete();
            if (bit_valid) begin
                q.push_back(bit_in);
                if (q.size() == 32) begin
                    w = 32'h0;
                    for (int i = 0; i < 32; i++) w = w + (32'(q[i]) << i);
                    q.delete();
                    if (!m_valid || word_ready) begin
                        m_word  = w;
                        m_valid = 1'b1;
                        loaded  = 1'b1;
                    end else begin
                        m_over = 1'b1;
                    end
                end
            end
            if (consume && !loaded) m_valid = 1'b0;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("sel_out", 32'(sel_out), 32'(q.size()));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("word_valid", 32'(word_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_over));
        if (m_valid) chk("word_out", word_out, m_word);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit toggle);
        for (int i = 0; i < 32; i++) begin
            bit_in    = w[i];
            bit_valid = 1'b1;
            tick();
            if (toggle) begin
                bit_valid = 1'b0;
                bit_in    = ~w[i];
                tick();
            end
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        #12;
        chk("reset_sel", 32'(sel_out), 32'h0);
        chk("reset_word", word_out, 32'h0);
        chk("reset_valid", 32'(word_valid), 32'h0);
        chk("reset_flags", {30'h0, busy, overrun}, 32'h0);
        reset = 1'b0;
        tick();

        // Full-rate frame with consumer ready.
        word_ready = 1'b1;
        send_word(32'hDEADBEEF, 1'b0);
        chk("t1_valid", 32'(word_valid), 32'h1);
        chk("t1_word", word_out, 32'hDEADBEEF);
        chk("t1_model_word", m_word, 32'hDEADBEEF);
        chk("t1_sel", 32'(sel_out), 32'h0);
        chk("t1_over", 32'(overrun), 32'h0);
        tick();
        chk("t1_pulse_end", 32'(word_valid), 32'h0);

        // Half-rate frame.
        send_word(32'hDEADBEEF, 1'b1);
        chk("t2_word", word_out, 32'hDEADBEEF);
        tick();

        // Two frames with the consumer stalled: second is dropped.
        word_ready = 1'b0;
        send_word(32'h00000001, 1'b0);
        chk("t3_first", word_out, 32'h00000001);
        send_word(32'h80000000, 1'b0);
        chk("t3_hold", word_out, 32'h00000001);
        chk("t3_over", 32'(overrun), 32'h1);
        chk("t3_valid", 32'(word_valid), 32'h1);
        word_ready = 1'b1;
        tick();
        chk("t3_drain", 32'(word_valid), 32'h0);

        // Partial frame aborted by start carrying bit 0.
        for (int i = 0; i < 10; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1; tick();
        end
        chk("t4_partial", 32'(sel_out), 32'd10);
        start = 1'b1; bit_in = 1'b0; bit_valid = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart", 32'(sel_out), 32'd1);
        for (int i = 0; i < 31; i++) begin
            bit_in = 1'b0; bit_valid = 1'b1; tick();
        end
        bit_valid = 1'b0;
        chk("t4_word", word_out, 32'h0);
        chk("t4_valid", 32'(word_valid), 32'h1);
        tick();

        // Clear overrun, then completion coincident with consume.
        reset = 1'b1; #2; reset = 1'b0;
        tick();
        word_ready = 1'b0;
        send_word(32'h12345678, 1'b0);
        for (int i = 0; i < 32; i++) begin
            bit_in = 32'h0F0F0F0F >> i;
            bit_valid = 1'b1;
            word_ready = (i == 31);
            tick();
        end
        bit_valid = 1'b0; word_ready = 1'b0;
        chk("t5_word", word_out, 32'h0F0F0F0F);
        chk("t5_valid", 32'(word_valid), 32'h1);
        chk("t5_over", 32'(overrun), 32'h0);
        word_ready = 1'b1;
        tick();

        // Asynchronous reset mid-frame at index 17.
        for (int i = 0; i < 17; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1; tick();
        end
        bit_valid = 1'b0;
        chk("t6_pre", 32'(sel_out), 32'd17);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_sel", 32'(sel_out), 32'h0);
        chk("t6_async_busy", 32'(busy), 32'h0);
        chk("t6_async_valid", 32'(word_valid), 32'h0);
        #2;
        reset = 1'b0;
        tick();
        send_word(32'hA5A5A5A5, 1'b0);
        chk("t6_word", word_out, 32'hA5A5A5A5);
        tick();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            bit_valid  = ($urandom_range(0, 3) != 0);
            bit_in     = $urandom_range(0, 1);
            word_ready = ($urandom_range(0, 1) == 1);
            start      = ($urandom_range(0, 199) == 0);
            tick();
        end
        start = 1'b0; bit_valid = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demux32_deser

// File: doc/demux32_deser.md
Name: demux32_deser

Overview:
- Serial-to-parallel receiver: the counterpart of the mux-based bit serializer.
- A transmitter walks a 5-bit select across a 32-bit word and sends one bit per beat. This block takes those bits and uses a 5:32 one-hot decoder to steer each bit into its position in a shadow word.
- After 32 beats it presents the assembled word on a valid/ready output port.
- It sits on the CPU's serial debug/load path, feeding words into the datapath.

Parameters:
- WIDTH, 32, word width. Must be a power of two. Only 32 is verified.
- IDX_W, 5, index width, equal to $clog2(WIDTH). Derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high. Clears all state.
- start  input  1  synchronous frame restart. Aborts any partial word.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle and is consumed.
- sel_out  output  IDX_W  current bit index, i.e. the position the next bit will land in.
- word_out  output  WIDTH  assembled word. Stable while word_valid=1.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out when word_valid=1.
- busy  output  1  high when sel_out != 0, i.e. a partial frame is in progress.
- overrun  output  1  sticky error flag. Cleared only by reset.

Behaviour:
- Reset (async, active-high):
  - sel_out=0, shadow word=0, word_out=0.
  - word_valid=0, overrun=0, busy=0.
- Fill:
  - On each clk edge with bit_valid=1: shadow[sel_out] <= bit_in. All other shadow bits hold.
  - Write enables come from the one-hot decode of sel_out, gated by bit_valid.
  - sel_out then increments modulo WIDTH, so 31 wraps to 0.
- bit_valid=0: no state change in the fill path.
- Completion (bit_valid=1 and sel_out=31):
  - The completed word is the shadow with bit 31 replaced by bit_in.
  - The completed word is loaded into word_out on the same edge.
  - word_valid=1 from the next cycle. Latency is 1 clock from the last bit's edge to valid visible.
- Shadow after completion: not cleared. Bits are overwritten as the next frame fills.
- Output handshake:
  - A word is consumed on an edge where word_valid=1 and word_ready=1.
  - After consumption, word_valid falls unless a new completion occurs on the same edge.
- Completion and consume on the same edge: the new word is loaded and word_valid stays 1. No overrun.
- Completion while word_valid=1 and word_ready=0:
  - The new word is dropped; word_out keeps the old word.
  - overrun <= 1.
  - sel_out still wraps to 0.
- start=1:
  - sel_out <= 0 and shadow <= 0. word_out, word_valid and overrun are unaffected.
  - If bit_valid=1 on the same cycle, the bit is written as bit 0 and sel_out <= 1. start has priority over the old index.
- word_ready while word_valid=0: ignored.
- Reset mid-frame: the partial word is lost and all outputs return to reset values immediately (asynchronous).
- Single-cycle rate: one bit per clock, back-to-back, with no bubbles required between frames.

Decomposition:
- Shared CPU package:
  - localparam WORD_W=32 and IDX_W=$clog2(WORD_W).
  - typedef logic [IDX_W-1:0] bit_idx_t.
- Natural sub-module: decoder5_32.
  - Combinational 5:32 one-hot decoder with an enable input.
  - It is the structural inverse of the 32:1 bit mux.
  - Instantiated once for the shadow write enables.
- Remaining RTL: index counter, shadow register, output register, valid/overrun flops.

Test Plan:
- Send 32'hDEADBEEF LSB-first with bit_valid=1 every cycle and word_ready=1 -> word_valid pulses 1 cycle after bit 31, word_out=32'hDEADBEEF, sel_out back to 0, overrun=0.
- Same word with bit_valid toggling 1/0 each cycle -> identical word_out. sel_out advances only on valid cycles. Completion comes after 64 cycles.
- Two back-to-back frames 32'h00000001 then 32'h80000000, word_ready=0 throughout -> word_out holds 32'h00000001, overrun=1 after the second frame. Raising word_ready then drops word_valid.
- Partial frame of 10 bits all 1, then start with bit_valid=1, bit_in=0, then 31 more 0 bits -> word_out=32'h00000000 and sel_out sequence restarts at 1.
- Completion edge coincident with word_ready=1 on a held word -> the new word replaces the old, word_valid stays 1, overrun stays 0.
- Assert reset asynchronously mid-frame at sel_out=17 -> all outputs go to 0 without waiting for clk. The next full frame of 32'hA5A5A5A5 assembles correctly.
